// File: rtl/camera_pkg.sv
// Shared types and widths for the camera frame capture block.
package camera_pkg;
  localparam int PIX_IN_W  = 12;
  localparam int PIX_OUT_W = 8;
  localparam int WORD_W    = 32;
  localparam int FIFO_W    = WORD_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    FLUSH_HOLD,
    FLUSH_PART
  } state_t;
endpackage

// File: rtl/camera_word_fifo.sv
// First-word-fall-through FIFO; rd_data is zero while empty so idle outputs read as 0.
module camera_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 34
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/camera_frame_capture.sv
// Captures 8-bit pixels from a camera strobe interface and packs them four per word
// into a FWFT stream with start/end-of-frame flags.
module camera_frame_capture
  import camera_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_valid,
  input  logic                line_valid,
  input  logic [PIX_IN_W-1:0] data,
  input  logic                overflow_clr,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_sof,
  output logic                out_eof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                overflow,
  output logic                frame_done,
  output logic [CNT_W-1:0]    last_lines,
  output logic [CNT_W-1:0]    last_line_pixels,
  output state_t              dbg_state
);
  // Stream handshake: a word transfers on a rising clk edge where out_valid && out_ready;
  // while out_valid=1 and out_ready=0 the word and its flags hold steady.
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  state_t                 state, state_nxt;
  logic                   fv_q, lv_q;
  logic [23:0]            pack;
  logic [1:0]             pack_cnt;
  logic [WORD_W-1:0]      hold;
  logic                   hold_valid;
  logic                   sof_pending;
  logic [CNT_W-1:0]       line_cnt, pix_cnt;
  logic [PIX_OUT_W-1:0]   px;
  logic                   frame_start, pix_accept, line_start, line_end;
  logic                   fifo_wr, fifo_full, fifo_empty, ovf_set;
  logic [FIFO_W-1:0]      fifo_wdata, fifo_rdata;
  logic [FIFO_AW:0]       fifo_count_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign px          = data[PIX_IN_W-1 -: PIX_OUT_W];
  // Only a fresh rising frame_valid starts capture, so a frame already under way is skipped.
  assign frame_start = (state == WAIT_FRAME) && frame_valid && !fv_q;
  assign pix_accept  = (state == CAPTURE) && frame_valid && line_valid;
  assign line_start  = pix_accept && !lv_q;
  assign line_end    = (state == CAPTURE) && lv_q && (!line_valid || !frame_valid);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (enable && !frame_valid) state_nxt = WAIT_FRAME;
      WAIT_FRAME: begin
        if (frame_start)  state_nxt = CAPTURE;
        else if (!enable) state_nxt = IDLE;
      end
      CAPTURE:    if (!frame_valid) state_nxt = FLUSH_HOLD;
      FLUSH_HOLD: state_nxt = FLUSH_PART;
      FLUSH_PART: state_nxt = enable ? WAIT_FRAME : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr    = 1'b0;
    fifo_wdata = {sof_pending, 1'b0, hold};
    case (state)
      CAPTURE:    fifo_wr = pix_accept && hold_valid;
      FLUSH_HOLD: begin
        fifo_wr    = hold_valid;
        fifo_wdata = {sof_pending, (pack_cnt == 2'd0), hold};
      end
      FLUSH_PART: begin
        fifo_wr    = (pack_cnt != 2'd0);
        fifo_wdata = {sof_pending, 1'b1, 8'h00, pack};
      end
      default: ;
    endcase
  end

  assign ovf_set = fifo_wr && fifo_full && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fv_q             <= 1'b0;
      lv_q             <= 1'b0;
      pack             <= '0;
      pack_cnt         <= '0;
      hold             <= '0;
      hold_valid       <= 1'b0;
      sof_pending      <= 1'b0;
      line_cnt         <= '0;
      pix_cnt          <= '0;
      last_lines       <= '0;
      last_line_pixels <= '0;
      overflow         <= 1'b0;
    end else begin
      fv_q <= frame_valid;
      lv_q <= line_valid;
      if (frame_start) begin
        pack        <= '0;
        pack_cnt    <= '0;
        hold_valid  <= 1'b0;
        sof_pending <= 1'b1;
        line_cnt    <= '0;
        pix_cnt     <= '0;
      end
      if (fifo_wr) begin
        sof_pending <= 1'b0;
        hold_valid  <= 1'b0;
      end
      if (pix_accept) begin
        // The packer is cleared on completion so a later partial word is zero-padded.
        if (pack_cnt == 2'd3) begin
          hold       <= {px, pack};
          hold_valid <= 1'b1;
          pack       <= '0;
        end else begin
          pack[8*pack_cnt +: 8] <= px;
        end
        pack_cnt <= pack_cnt + 2'd1;
        pix_cnt  <= line_start ? CNT_W'(1) : sat_inc(pix_cnt);
      end
      if (line_end) line_cnt <= sat_inc(line_cnt);
      if (state == FLUSH_HOLD) begin
        last_lines       <= line_cnt;
        last_line_pixels <= pix_cnt;
      end
      if (state == FLUSH_PART) begin
        pack       <= '0;
        pack_cnt   <= '0;
        hold_valid <= 1'b0;
      end
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  camera_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (out_ready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign {out_sof, out_eof, out_data} = fifo_rdata;
  assign out_valid  = !fifo_empty;
  assign busy       = (state != IDLE);
  assign frame_done = (state == FLUSH_PART);
  assign dbg_state  = state;
endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture: directed scenarios plus random frames, checked against
// a byte-queue packing model of each frame.
module tb_camera_frame_capture;
  import camera_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              frame_valid = 1'b0;
  logic              line_valid = 1'b0;
  logic [11:0]       data = '0;
  logic              overflow_clr = 1'b0;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_sof, out_eof, out_valid;
  logic              busy, overflow, frame_done;
  logic [CNT_W-1:0]  last_lines, last_line_pixels;
  state_t            dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  int          exp_lines_q[$];
  int          exp_pix_q[$];
  int          fd_count = 0;
  int          ready_mode = 0;
  logic [11:0] pix_mem [0:511];
  int          line_len [0:7];

  // clock / reset
  always #5 clk = ~clk;

  camera_frame_capture #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .frame_valid      (frame_valid),
    .line_valid       (line_valid),
    .data             (data),
    .overflow_clr     (overflow_clr),
    .out_data         (out_data),
    .out_sof          (out_sof),
    .out_eof          (out_eof),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .overflow         (overflow),
    .frame_done       (frame_done),
    .last_lines       (last_lines),
    .last_line_pixels (last_line_pixels),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready has a single driver: 0 = hold low, 1 = always ready, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard: consumed words, output stability under backpressure, frame_done statistics
  initial begin
    logic [33:0] prev_word;
    logic [33:0] exp_w;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 34'(out_valid), 34'd1);
          check("stall_word", {out_sof, out_eof, out_data}, prev_word);
        end
        if (out_valid && out_ready) begin
          check("word_expected", 34'(exp_q.size() != 0), 34'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("word", {out_sof, out_eof, out_data}, exp_w);
          end
        end
        if (frame_done) begin
          fd_count++;
          check("done_expected", 34'(exp_lines_q.size() != 0), 34'd1);
          if (exp_lines_q.size() != 0) begin
            check("done_lines", 34'(last_lines), 34'(exp_lines_q.pop_front()));
            check("done_pixels", 34'(last_line_pixels), 34'(exp_pix_q.pop_front()));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_sof, out_eof, out_data};
      end
    end
  end

  // Reference: the accepted bytes of a frame, four per word, low byte first.
  task automatic expect_frame(input int n_lines, input int keep);
    logic [7:0]  bytes[$];
    logic [31:0] word;
    int          idx;
    int          nw;
    idx = 0;
    for (int l = 0; l < n_lines; l++)
      for (int p = 0; p < line_len[l]; p++) begin
        bytes.push_back(pix_mem[idx][11:4]);
        idx++;
      end
    nw = (bytes.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < bytes.size()) word[8*b +: 8] = bytes[4*w + b];
      if (keep < 0 || w < keep) exp_q.push_back({(w == 0), (w == nw - 1), word});
    end
    exp_lines_q.push_back(n_lines);
    exp_pix_q.push_back(line_len[n_lines-1]);
  endtask

  task automatic drive_frame(input int n_lines, input int drop_en_line, input bit clr_at_flush);
    int idx;
    idx = 0;
    frame_valid = 1'b1;
    tick();
    tick();
    for (int l = 0; l < n_lines; l++) begin
      if (l == drop_en_line) enable = 1'b0;
      line_valid = 1'b1;
      for (int p = 0; p < line_len[l]; p++) begin
        data = pix_mem[idx];
        idx++;
        tick();
      end
      line_valid = 1'b0;
      data = 12'($urandom);
      repeat (1 + $urandom_range(0, 2)) tick();
    end
    frame_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      overflow_clr = clr_at_flush && (dbg_state == FLUSH_HOLD);
      tick();
    end
    overflow_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_lines_q.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    check("drain_words", 34'(exp_q.size()), 34'd0);
    check("drain_frames", 34'(exp_lines_q.size()), 34'd0);
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) pix_mem[i] = 12'((i + 1) * 16);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix_mem[i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_out_valid"}, 34'(out_valid), 34'd0);
    check({pfx, "_out_data"}, 34'(out_data), 34'd0);
    check({pfx, "_out_sof"}, 34'(out_sof), 34'd0);
    check({pfx, "_out_eof"}, 34'(out_eof), 34'd0);
    check({pfx, "_busy"}, 34'(busy), 34'd0);
    check({pfx, "_overflow"}, 34'(overflow), 34'd0);
    check({pfx, "_frame_done"}, 34'(frame_done), 34'd0);
    check({pfx, "_last_lines"}, 34'(last_lines), 34'd0);
    check({pfx, "_last_pixels"}, 34'(last_line_pixels), 34'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int nl;
    int tot;

    reset = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    enable = 1'b1;
    ready_mode = 1;
    repeat (2) tick();

    // 8x2 ramp frame
    fill_ramp(16);
    line_len[0] = 8;
    line_len[1] = 8;
    expect_frame(2, -1);
    drive_frame(2, -1, 1'b0);
    wait_drain();
    check("t1_last_lines", 34'(last_lines), 34'd2);
    check("t1_last_pixels", 34'(last_line_pixels), 34'd8);

    // 6-pixel single line: full word then zero-padded partial
    fd0 = fd_count;
    fill_ramp(6);
    line_len[0] = 6;
    expect_frame(1, -1);
    drive_frame(1, -1, 1'b0);
    wait_drain();
    check("t2_done_pulses", 34'(fd_count - fd0), 34'd1);

    // 4-pixel frame: one word carrying both sof and eof
    fill_ramp(4);
    line_len[0] = 4;
    expect_frame(1, -1);
    drive_frame(1, -1, 1'b0);
    wait_drain();

    // backpressure: 40 words offered, only the first FIFO_DEPTH survive
    ready_mode = 0;
    repeat (2) tick();
    fill_random(160);
    for (int l = 0; l < 4; l++) line_len[l] = 40;
    expect_frame(4, FIFO_DEPTH);
    drive_frame(4, -1, 1'b0);
    check("ovf_set", 34'(overflow), 34'd1);
    check("ovf_fifo_valid", 34'(out_valid), 34'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", 34'(overflow), 34'd0);
    // a dropped write coinciding with overflow_clr keeps the flag set
    fill_ramp(4);
    line_len[0] = 4;
    expect_frame(1, 0);
    drive_frame(1, -1, 1'b1);
    check("ovf_set_wins", 34'(overflow), 34'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr2", 34'(overflow), 34'd0);
    ready_mode = 1;
    wait_drain();
    repeat (3) tick();
    check("ovf_fifo_empty", 34'(out_valid), 34'd0);

    // enable dropped mid-frame: frame completes, then idle
    fill_random(15);
    line_len[0] = 5;
    line_len[1] = 7;
    line_len[2] = 3;
    expect_frame(3, -1);
    drive_frame(3, 1, 1'b0);
    wait_drain();
    tick();
    check("en_drop_busy", 34'(busy), 34'd0);

    // enable raised during a frame: that frame is ignored
    frame_valid = 1'b1;
    tick();
    enable = 1'b1;
    repeat (2) tick();
    line_valid = 1'b1;
    repeat (8) begin
      data = 12'($urandom);
      tick();
    end
    line_valid = 1'b0;
    tick();
    check("late_en_busy", 34'(busy), 34'd0);
    frame_valid = 1'b0;
    repeat (3) tick();
    check("late_en_wait", 34'(busy), 34'd1);
    fill_ramp(5);
    line_len[0] = 5;
    expect_frame(1, -1);
    drive_frame(1, -1, 1'b0);
    wait_drain();

    // reset in the middle of a line
    ready_mode = 0;
    repeat (2) tick();
    frame_valid = 1'b1;
    repeat (2) tick();
    line_valid = 1'b1;
    repeat (6) begin
      data = 12'($urandom);
      tick();
    end
    check("pre_rst_valid", 34'(out_valid), 34'd1);
    reset = 1'b1;
    tick();
    check_zero_outputs("midrst");
    reset = 1'b0;
    repeat (3) begin
      data = 12'($urandom);
      tick();
    end
    line_valid = 1'b0;
    tick();
    frame_valid = 1'b0;
    repeat (3) tick();
    ready_mode = 1;
    repeat (3) tick();
    check("rst_no_word", 34'(out_valid), 34'd0);
    fill_random(7);
    line_len[0] = 4;
    line_len[1] = 3;
    expect_frame(2, -1);
    drive_frame(2, -1, 1'b0);
    wait_drain();

    // random frames with random backpressure
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      nl = $urandom_range(1, 3);
      tot = 0;
      for (int l = 0; l < nl; l++) begin
        line_len[l] = $urandom_range(1, 12);
        tot += line_len[l];
      end
      fill_random(tot);
      expect_frame(nl, -1);
      drive_frame(nl, -1, 1'b0);
    end
    wait_drain();
    check("rand_no_ovf", 34'(overflow), 34'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
